pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage, and the successor to the single-source PC register. It selects the next fetch address from trap, flush, branch and jump redirects in fixed priority. It adds a configurable reset vector, a valid/ready fetch handshake with redirect bubbles, and a small return-address stack (RAS) for call/return prediction.

---
 rtl/pc_gen_pkg.sv | 26 ++
 rtl/pc_ras.sv | 59 +++++
 rtl/pc_gen.sv | 123 ++++++++++++
 tb/tb_pc_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
// Holds the FSM states, the redirect-cause encoding and the alignment mask.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    BUBBLE
  } fsm_state_t;

  typedef enum logic [2:0] {
    NONE,
    TRAP,
    FLUSH,
    BRANCH,
    JUMP
  } redirect_t;

  // Keeps every bit except the low log2(inst_bytes) bits; inst_bytes must be a power of two.
  function automatic logic [63:0] align_mask(input int unsigned inst_bytes);
    logic [63:0] low_bits;
    low_bits = 64'(inst_bytes) - 64'd1;
    return ~low_bits;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack for call/return prediction.
// When full, a push overwrites the oldest entry and the count stays saturated.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_COUNT = CW'(RAS_DEPTH);

  logic [XLEN-1:0] entries [RAS_DEPTH];
  logic [PW-1:0]   top_ptr;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;
  logic [CW-1:0]   count;

  assign ptr_inc = top_ptr + PW'(1);
  assign ptr_dec = top_ptr - PW'(1);
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_COUNT);
  assign top     = entries[top_ptr];

  // push+pop on a non-empty stack replaces the top; on an empty stack it acts as a plain push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entries[i] <= '0;
      end
      top_ptr <= '0;
      count   <= '0;
    end else if (clear) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push && pop && !empty) begin
      entries[top_ptr] <= push_data;
    end else if (push) begin
      entries[ptr_inc] <= push_data;
      top_ptr          <= ptr_inc;
      if (!full) begin
        count <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      top_ptr <= ptr_dec;
      count   <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: prioritised redirects, reset vector,
// valid/ready fetch handshake with redirect bubbles, and RAS-based return prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              INST_BYTES = 4,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_n,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_addr,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_addr,
  input  logic            call,
  input  logic [XLEN-1:0] call_ret_addr,
  input  logic            ret,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(INST_BYTES));
  localparam logic [XLEN-1:0] INST_STEP  = XLEN'(INST_BYTES);

  fsm_state_t      state;
  fsm_state_t      next_state;
  redirect_t       cause;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_clear;
  logic            advance;

  always_comb begin
    cause = NONE;
    if (trap) begin
      cause = TRAP;
    end else if (flush) begin
      cause = FLUSH;
    end else if (branch_taken) begin
      cause = BRANCH;
    end else if (jump) begin
      cause = JUMP;
    end
  end

  // call/ret only act on the RAS when the jump is the winning redirect.
  always_comb begin
    target    = '0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    unique case (cause)
      TRAP: begin
        target    = trap_vec;
        ras_clear = 1'b1;
      end
      FLUSH:  target = flush_addr;
      BRANCH: target = branch_target;
      JUMP: begin
        target   = (ret && !ras_empty) ? ras_top : jump_addr;
        ras_pop  = ret && !ras_empty;
        ras_push = call;
      end
      default: target = '0;
    endcase
  end

  always_comb begin
    next_state = state;
    unique case (state)
      BOOT:    next_state = RUN;
      RUN:     next_state = (trap || flush) ? BUBBLE : RUN;
      BUBBLE:  next_state = (trap || flush) ? BUBBLE : RUN;
      default: next_state = BOOT;
    endcase
  end

  assign advance = fetch_valid && fetch_ready && stall_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_valid <= 1'b0;
      pc          <= RESET_VEC;
    end else begin
      state       <= next_state;
      fetch_valid <= (next_state == RUN);
      if (cause != NONE) begin
        pc <= target & ALIGN_MASK;
      end else if (advance) begin
        pc <= pc + INST_STEP;
      end
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (call_ret_addr & ALIGN_MASK),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with RESET_VEC=0x100, INST_BYTES=4, RAS_DEPTH=4.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        stall_n;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc;
  logic        trap;
  logic [31:0] trap_vec;
  logic        flush;
  logic [31:0] flush_addr;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_addr;
  logic        call;
  logic [31:0] call_ret_addr;
  logic        ret;
  logic        ras_empty;
  logic        ras_full;

  int passed = 0;
  int total  = 0;

  pc_gen #(
    .XLEN       (32),
    .RESET_VEC  (32'h100),
    .INST_BYTES (4),
    .RAS_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_n       (stall_n),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .pc            (pc),
    .trap          (trap),
    .trap_vec      (trap_vec),
    .flush         (flush),
    .flush_addr    (flush_addr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .call          (call),
    .call_ret_addr (call_ret_addr),
    .ret           (ret),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clear_redirects();
    trap          = 1'b0;
    trap_vec      = '0;
    flush         = 1'b0;
    flush_addr    = '0;
    branch_taken  = 1'b0;
    branch_target = '0;
    jump          = 1'b0;
    jump_addr     = '0;
    call          = 1'b0;
    call_ret_addr = '0;
    ret           = 1'b0;
  endtask

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] ret_targets [5];

  initial begin
    ret_targets[0] = 32'h54;
    ret_targets[1] = 32'h44;
    ret_targets[2] = 32'h34;
    ret_targets[3] = 32'h24;
    ret_targets[4] = 32'h998;

    rst_n       = 1'b0;
    stall_n     = 1'b1;
    fetch_ready = 1'b1;
    clear_redirects();
    @(negedge clk);
    @(negedge clk);
    check_output("reset_pc", pc, 32'h100);
    check_output("reset_valid", {31'b0, fetch_valid}, 32'd0);
    check_output("reset_ras_empty", {31'b0, ras_empty}, 32'd1);
    check_output("reset_ras_full", {31'b0, ras_full}, 32'd0);

    rst_n = 1'b1;
    check_output("boot_valid", {31'b0, fetch_valid}, 32'd0);
    tick();
    check_output("run_pc0", pc, 32'h100);
    check_output("run_valid", {31'b0, fetch_valid}, 32'd1);
    tick();
    check_output("run_pc1", pc, 32'h104);

    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("hold_pc", pc, 32'h104);
    end
    fetch_ready = 1'b1;
    tick();
    check_output("ready_pc", pc, 32'h108);
    tick();
    check_output("seq_pc", pc, 32'h10C);

    jump = 1'b1; call = 1'b1; jump_addr = 32'h300; call_ret_addr = 32'h10C;
    tick();
    clear_redirects();
    check_output("call_pc", pc, 32'h300);
    check_output("call_ras_empty", {31'b0, ras_empty}, 32'd0);

    trap = 1'b1; trap_vec = 32'h800;
    flush = 1'b1; flush_addr = 32'h40;
    jump = 1'b1; jump_addr = 32'h20; call = 1'b1; call_ret_addr = 32'h70;
    tick();
    clear_redirects();
    check_output("trap_pc", pc, 32'h800);
    check_output("trap_bubble", {31'b0, fetch_valid}, 32'd0);
    check_output("trap_ras_clear", {31'b0, ras_empty}, 32'd1);
    tick();
    check_output("post_trap_pc", pc, 32'h800);
    check_output("post_trap_valid", {31'b0, fetch_valid}, 32'd1);
    tick();
    check_output("post_trap_seq", pc, 32'h804);

    flush = 1'b1; flush_addr = 32'h40;
    tick();
    check_output("flush_pc", pc, 32'h40);
    check_output("flush_bubble", {31'b0, fetch_valid}, 32'd0);
    flush_addr = 32'h60;
    tick();
    clear_redirects();
    check_output("reflush_pc", pc, 32'h60);
    check_output("reflush_bubble", {31'b0, fetch_valid}, 32'd0);
    tick();
    check_output("post_flush_pc", pc, 32'h60);
    check_output("post_flush_valid", {31'b0, fetch_valid}, 32'd1);
    tick();
    check_output("post_flush_seq", pc, 32'h64);

    for (int i = 0; i < 5; i++) begin
      jump = 1'b1; call = 1'b1; jump_addr = 32'h1000;
      call_ret_addr = 32'h14 + 32'(i) * 32'h10;
      tick();
      check_output("push_pc", pc, 32'h1000);
      check_output("push_full", {31'b0, ras_full}, (i >= 3) ? 32'd1 : 32'd0);
    end
    clear_redirects();
    for (int i = 0; i < 5; i++) begin
      jump = 1'b1; ret = 1'b1; jump_addr = 32'h999;
      tick();
      check_output("ret_pc", pc, ret_targets[i]);
    end
    clear_redirects();
    check_output("ret_ras_empty", {31'b0, ras_empty}, 32'd1);
    check_output("ret_ras_full", {31'b0, ras_full}, 32'd0);

    jump = 1'b1; call = 1'b1; jump_addr = 32'h200; call_ret_addr = 32'h100;
    tick();
    check_output("cr_push_pc", pc, 32'h200);
    ret = 1'b1; jump_addr = 32'h400; call_ret_addr = 32'h300;
    tick();
    check_output("cr_swap_pc", pc, 32'h100);
    check_output("cr_swap_nonempty", {31'b0, ras_empty}, 32'd0);
    call = 1'b0;
    tick();
    check_output("cr_ret_pc", pc, 32'h300);
    check_output("cr_ret_empty", {31'b0, ras_empty}, 32'd1);

    call = 1'b1; ret = 1'b1; jump_addr = 32'h500; call_ret_addr = 32'h3C;
    tick();
    check_output("cr_empty_pc", pc, 32'h500);
    check_output("cr_empty_count1", {31'b0, ras_empty}, 32'd0);
    call = 1'b0; jump_addr = 32'h600;
    tick();
    clear_redirects();
    check_output("cr_empty_ret_pc", pc, 32'h3C);
    check_output("cr_empty_ret_empty", {31'b0, ras_empty}, 32'd1);

    jump = 1'b1; call = 1'b1; jump_addr = 32'h0; call_ret_addr = 32'h44;
    tick();
    clear_redirects();
    branch_taken = 1'b1; branch_target = 32'hA0;
    jump = 1'b1; ret = 1'b1; jump_addr = 32'h10;
    tick();
    clear_redirects();
    check_output("branch_over_jump_pc", pc, 32'hA0);
    check_output("branch_keeps_ras", {31'b0, ras_empty}, 32'd0);
    flush = 1'b1; flush_addr = 32'h80;
    branch_taken = 1'b1; branch_target = 32'h90;
    tick();
    clear_redirects();
    check_output("flush_over_branch_pc", pc, 32'h80);
    check_output("flush_keeps_ras", {31'b0, ras_empty}, 32'd0);

    tick();
    stall_n = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h202;
    tick();
    clear_redirects();
    check_output("stall_branch_pc", pc, 32'h200);
    check_output("stall_branch_valid", {31'b0, fetch_valid}, 32'd1);
    tick();
    check_output("stall_hold_pc", pc, 32'h200);
    stall_n = 1'b1;
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    clear_redirects();
    check_output("top_addr_pc", pc, 32'hFFFF_FFFC);
    tick();
    check_output("wrap_pc", pc, 32'h0);

    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_pc", pc, 32'h100);
    check_output("async_reset_valid", {31'b0, fetch_valid}, 32'd0);
    check_output("async_reset_ras", {31'b0, ras_empty}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h302;
    tick();
    clear_redirects();
    check_output("boot_redirect_pc", pc, 32'h300);
    check_output("boot_redirect_valid", {31'b0, fetch_valid}, 32'd1);
    tick();
    check_output("boot_redirect_seq", pc, 32'h304);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
